// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 serial receiver feeding a small first-word-fall-through
// byte FIFO. The status bits for frame error and overrun stay set until cleared.
module uart_rx_buffered #(
  parameter int CLOCK_SPEED = 2_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_serial_in_data,
  input  logic                          rd_en,
  input  logic                          clr_status,
  output logic [7:0]                    rd_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [1:0]                    status_reg
);

  localparam int CPB = CLOCK_SPEED / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, cnt_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift_q, shift_n;
  logic          rx_meta, rx_sync;
  logic          push_req, frame_err;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, do_push, do_pop, overrun;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial_in_data;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= idx_n;
      shift_q  <= shift_n;
    end
  end

  // Next-state logic: sample at mid-bit, shift LSB first, judge the stop bit.
  always_comb begin
    state_n   = state;
    cnt_n     = baud_cnt + 1'b1;
    idx_n     = bit_idx;
    shift_n   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = S_START;
      end
      S_START: begin
        if (baud_cnt == HALF_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == BIT_END) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift_q[7:1]};
          idx_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_sync) begin
            push_req = 1'b1;
            state_n  = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low after a bad stop bit must not look like a new start.
        cnt_n = '0;
        if (rx_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign full     = (count == FULL_CNT);
  assign do_pop   = rd_en && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push  = push_req && (!full || do_pop);
  assign overrun  = push_req && full && !do_pop;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status; a same-cycle error event wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) status_reg <= 2'b00;
    else       status_reg <= (clr_status ? 2'b00 : status_reg) | {overrun, frame_err};
  end

  assign rd_data  = mem[rd_ptr];
  assign rx_empty = (count == '0);
  assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered: frames are driven on the serial line, a queue
// model of the receive FIFO and its sticky status predicts every popped byte.
module tb_uart_rx_buffered;

  localparam int CPB      = 2_000_000 / 9600;
  localparam int DEPTH    = 4;
  // Edges from the start-bit drive to the stop-bit decision edge:
  // two sync flops, one IDLE detect, half a bit in START, nine full bits.
  localparam int PUSH_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial_in_data;
  logic       rd_en;
  logic       clr_status;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic [2:0] rx_count;
  logic [1:0] status_reg;

  logic [7:0] exp_q[$];
  bit         m_ferr, m_ovr;
  int         tests, fails;

  uart_rx_buffered #(.CLOCK_SPEED(2_000_000), .BAUD_RATE(9600), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_serial_in_data(rx_serial_in_data), .rd_en(rd_en),
    .clr_status(clr_status), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .status_reg(status_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must return the model's head byte.
  always @(negedge clk) begin
    if (!reset && rd_en && !rx_empty) begin
      if (exp_q.size() == 0) check("pop_unexpected", {24'h0, rd_data}, 32'hFFFF_FFFF);
      else                   check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic check_state(input string name);
    check({name, "_count"}, 32'(rx_count), 32'(exp_q.size()));
    check({name, "_empty"}, 32'(rx_empty), 32'(exp_q.size() == 0));
    check({name, "_status"}, 32'(status_reg), {30'h0, m_ovr, m_ferr});
    if (exp_q.size() > 0) check({name, "_head"}, {24'h0, rd_data}, {24'h0, exp_q[0]});
  endtask

  // Drive one 8N1 frame; hold_low extends a bad stop bit before the line idles.
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input int hold_low);
    @(posedge clk); #1 rx_serial_in_data = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_serial_in_data = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_serial_in_data = !bad_stop;
    repeat (CPB) @(posedge clk);
    if (bad_stop) m_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else m_ovr = 1'b1;
    repeat (hold_low) @(posedge clk);
    #1 rx_serial_in_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pop();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic clear();
    @(posedge clk); #1 clr_status = 1'b1;
    @(posedge clk); #1 clr_status = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bit         bad;
    int         hold, npop;
    reset = 1'b1; rx_serial_in_data = 1'b1; rd_en = 1'b0; clr_status = 1'b0;
    tests = 0; fails = 0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_state("reset");
    check("reset_rd_data", {24'h0, rd_data}, 32'h0);

    // 1: single frame, exact visibility edge, then pop.
    fork
      send_frame(8'h41, 1'b0, 0);
      begin
        repeat (PUSH_LAT) @(posedge clk);
        #1 check("t1_empty_before_push", 32'(rx_empty), 32'd1);
        @(posedge clk);
        #1 check("t1_empty_after_push", 32'(rx_empty), 32'd0);
        check("t1_head_after_push", {24'h0, rd_data}, 32'h41);
      end
    join
    check_state("t1");
    pop();
    check_state("t1_drained");

    // 2: short low glitch is rejected, next frame is fine.
    @(posedge clk); #1 rx_serial_in_data = 1'b0;
    repeat (50) @(posedge clk);
    #1 rx_serial_in_data = 1'b1;
    repeat (CPB * 2) @(posedge clk);
    check_state("t2_glitch");
    send_frame(8'hA5, 1'b0, 0);
    check_state("t2");
    pop();

    // 3: bad stop bit, line held low, then a good frame.
    send_frame(8'h55, 1'b1, 3 * CPB);
    check_state("t3_ferr");
    send_frame(8'h3C, 1'b0, 0);
    check_state("t3");
    pop();
    clear();
    check_state("t3_clr");

    // 4: five frames without reads overrun a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 0);
    check_state("t4_full");
    repeat (4) pop();
    check_state("t4_drained");
    clear();
    check_state("t4_clr");

    // 5: pop exactly on the push edge while full: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 0);
    fork
      send_frame(8'h05, 1'b0, 0);
      begin
        repeat (PUSH_LAT) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    check_state("t5_full");
    repeat (4) pop();
    check_state("t5_drained");

    // 6: reset during data bit 4 with a byte queued and an error pending.
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b1, 0);
    check_state("t6_pre");
    d = 8'h5A;
    @(posedge clk); #1 rx_serial_in_data = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx_serial_in_data = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_serial_in_data = d[4];
    repeat (CPB / 2) @(posedge clk);
    #1 reset = 1'b1; rx_serial_in_data = 1'b1;
    exp_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_state("t6_reset");
    check("t6_rd_data", {24'h0, rd_data}, 32'h0);
    repeat (CPB * 2) @(posedge clk);
    send_frame(8'h7E, 1'b0, 0);
    check_state("t6");
    pop();

    // Randomised traffic: data, occasional bad stop bits, random pops and clears.
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      bad  = ($urandom_range(0, 5) == 0);
      hold = bad ? int'($urandom_range(0, 2 * CPB)) : 0;
      send_frame(d, bad, hold);
      npop = int'($urandom_range(0, 2));
      repeat (npop) pop();
      if ($urandom_range(0, 3) == 0) clear();
      check_state("rand");
    end
    repeat (DEPTH + 1) pop();
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
